des_iter_ctrl: RTL
==================

DES_ITER_CTRL -- requirements
Module: des_iter_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports are listed below, clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  a job is offered on plaintext/key/encry_decry.
REQ-005 in_ready  output  1  the block accepts a job this cycle.
REQ-006 plaintext  input  [1:64]  data block; bit 1 is the MSB.
REQ-007 key  input  [1:64]  key; bits 8,16,…,64 are parity bits.
REQ-008 encry_decry  input  1  0 = encrypt, 1 = decrypt.
REQ-009 out_valid  output  1  the result is valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 ciphertext  output  [1:64]  the result block.
REQ-012 inv_key  output  1  the accepted key failed the odd-parity check; qualified by out_valid.

Function
REQ-013 The FSM SHALL have states IDLE, ROUND and DONE; in_ready SHALL equal (state==IDLE).
REQ-014 On an IDLE edge with in_valid=1, the block SHALL do all of the following:
- Register L0/R0 = IP(plaintext) and C0/D0 = PC1(key).
- Latch encry_decry.
- Set the round counter to 1.
- Enter ROUND.
REQ-015 In ROUND, the block SHALL execute one Feistel round per clock, so rounds 1..16 complete on edges T+1..T+16 after the acceptance edge T.
- Each round: L<=R; R<=L^F(R,Kr).
REQ-016 For encryption, round r SHALL rotate C/D left by S[r] and use Kr = PC2(rotated C/D).
- The rotated C/D SHALL be stored.
- S = {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}.
REQ-017 For decryption, round r SHALL use Kr = PC2(current C/D).
- It SHALL then store C/D rotated right by S[17-r].
- The rotation is applied to each 28-bit half independently, with wrap-around.
REQ-018 On the edge completing round 16, the block SHALL enter DONE and register ciphertext = IP^-1({R16,L16}).
- out_valid SHALL be high from that edge, giving latency of 16 cycles from acceptance to out_valid.
REQ-019 In DONE, ciphertext and inv_key SHALL hold stable while out_ready=0.
- An edge with out_ready=1 SHALL return the FSM to IDLE.
- in_ready SHALL be 0 in the DONE cycle, so back-to-back throughput is one job per 18 cycles.
REQ-020 Inputs SHALL be ignored outside IDLE, and in_valid SHALL NOT need to be held after acceptance.
REQ-021 The round counter SHALL be 5 bits, SHALL count 1..16, and SHALL NOT wrap while in ROUND.

Reset
REQ-022 When rst is asserted, the block SHALL immediately do all of the following:
- Set state=IDLE.
- Set out_valid=0, inv_key=0 and ciphertext=0.
- Clear the round counter and all L/R/C/D registers.
- Set in_ready=1 after release.
REQ-023 A reset during ROUND or DONE SHALL discard the job, and no result SHALL be produced for that job.

Configuration
REQ-024 With DES_PARITY_CHECK_EN defined, the block SHALL compute per-byte odd parity at acceptance and latch inv_key.
- A failing job SHALL skip ROUND and enter DONE on the next edge with ciphertext=0 and inv_key=1.
REQ-025 Without DES_PARITY_CHECK_EN, inv_key SHALL be tied to 0 and every job SHALL run 16 rounds.

Structure
REQ-026 The shared package des_pkg SHALL hold:
- The state enum.
- The S[1:16] shift table.
- The round-count constant 16.
- The IP, IP^-1, PC1 and PC2 index tables.
REQ-027 The combinational function F (expansion E, key XOR, S1–S8, permutation P) SHALL be one sub-module, des_f, with one instance per des_iter_ctrl.

Verification
REQ-028 Encrypt known-answer test:
- Stimulus: key=133457799BBCDFF1, pt=0123456789ABCDEF, encry_decry=0.
- Response: out_valid 16 cycles after acceptance, ciphertext=85E813540F0AB405, inv_key=0.
REQ-029 Decrypt known-answer test:
- Stimulus: same key, input 85E813540F0AB405, encry_decry=1.
- Response: ciphertext=0123456789ABCDEF after 16 cycles.
REQ-030 Backpressure test:
- Stimulus: hold out_ready=0 for 5 cycles in DONE.
- Response: ciphertext stable, in_ready=0 throughout; IDLE one edge after out_ready=1.
REQ-031 Parity test with DES_PARITY_CHECK_EN:
- Stimulus: key=133457799BBCDFF0.
- Response: out_valid 1 cycle after acceptance, ciphertext=0, inv_key=1.
- Without the macro, the same key SHALL yield a normal 16-cycle result.
REQ-032 Reset mid-job test:
- Stimulus: assert rst at round 8.
- Response: out_valid=0 immediately; a new job accepted after release yields the correct known-answer result.
REQ-033 Back-to-back test:
- Stimulus: in_valid held high with out_ready=1 for two jobs.
- Response: second acceptance exactly 18 cycles after the first; both results are correct.

Source files
------------

// File: rtl/des_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : des_pkg
// Brief    : Shared DES types, tables and permutation helpers for des_iter_ctrl.
// Revision : 1.0
// ============================================================================
package des_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] ROUNDS = 5'd16;

    localparam int unsigned SHIFT_TBL [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int unsigned IP_TBL [1:64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int unsigned FP_TBL [1:64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int unsigned PC1_TBL [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TBL [1:48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // All tables use DES numbering: entry i names the source bit, bit 1 = MSB.
    function automatic logic [1:64] f_ip(input logic [1:64] d);
        logic [1:64] v;
        for (int i = 1; i <= 64; i++) v[i] = d[IP_TBL[i]];
        return v;
    endfunction

    function automatic logic [1:64] f_fp(input logic [1:64] d);
        logic [1:64] v;
        for (int i = 1; i <= 64; i++) v[i] = d[FP_TBL[i]];
        return v;
    endfunction

    function automatic logic [1:56] f_pc1(input logic [1:64] d);
        logic [1:56] v;
        for (int i = 1; i <= 56; i++) v[i] = d[PC1_TBL[i]];
        return v;
    endfunction

    function automatic logic [1:48] f_pc2(input logic [1:56] d);
        logic [1:48] v;
        for (int i = 1; i <= 48; i++) v[i] = d[PC2_TBL[i]];
        return v;
    endfunction

    function automatic logic [1:0] f_shift(input logic [4:0] r);
        logic [1:0] s;
        s = 2'd0;
        for (int i = 1; i <= 16; i++) begin
            if (r == 5'(i)) s = 2'(SHIFT_TBL[i]);
        end
        return s;
    endfunction

    function automatic logic [1:28] f_rotl28(input logic [1:28] c, input logic [1:0] n);
        return (n == 2'd2) ? {c[3:28], c[1:2]} : {c[2:28], c[1]};
    endfunction

    function automatic logic [1:28] f_rotr28(input logic [1:28] c, input logic [1:0] n);
        return (n == 2'd2) ? {c[27:28], c[1:26]} : {c[28], c[1:27]};
    endfunction

    // Each key byte must carry an odd number of ones.
    function automatic logic f_parity_bad(input logic [1:64] k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (^k[8*b+1 +: 8] == 1'b0) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_iter_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : des_iter_ctrl_if
// Brief    : Job/result handshake bundle between a DES client and des_iter_ctrl.
// Revision : 1.0
// ============================================================================
interface des_iter_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:64] plaintext;
    logic [1:64] key;
    logic        encry_decry;
    logic        out_valid;
    logic        out_ready;
    logic [1:64] ciphertext;
    logic        inv_key;

    modport master (
        output in_valid, plaintext, key, encry_decry, out_ready,
        input  in_ready, out_valid, ciphertext, inv_key
    );

    modport slave (
        input  in_valid, plaintext, key, encry_decry, out_ready,
        output in_ready, out_valid, ciphertext, inv_key
    );
endinterface
`default_nettype wire

// File: rtl/des_f.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : des_f
// Brief    : Combinational DES round function F(R, K): E, key mix, S1-S8, P.
// Revision : 1.0
// ============================================================================
module des_f (
    input  wire logic [1:32] i_r,
    input  wire logic [1:48] i_k,
    output logic      [1:32] o_f
);

    localparam int unsigned E_TBL [1:48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int unsigned P_TBL [1:32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Eight boxes of four 16-entry rows, indexed by box*64 + row*16 + col.
    localparam int unsigned SBOX_TBL [0:511] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
    };

    function automatic logic [1:48] f_expand(input logic [1:32] r);
        logic [1:48] v;
        for (int i = 1; i <= 48; i++) v[i] = r[E_TBL[i]];
        return v;
    endfunction

    // Outer bits b1/b6 pick the row, inner bits b2..b5 the column.
    function automatic logic [1:32] f_sbox(input logic [1:48] x);
        logic [1:32] v;
        logic [1:6]  b;
        logic [3:0]  s;
        v = '0;
        for (int n = 0; n < 8; n++) begin
            b = x[6*n+1 +: 6];
            s = 4'(SBOX_TBL[n*64 + int'({b[1], b[6], b[2:5]})]);
            v[4*n+1 +: 4] = s;
        end
        return v;
    endfunction

    function automatic logic [1:32] f_perm(input logic [1:32] d);
        logic [1:32] v;
        for (int i = 1; i <= 32; i++) v[i] = d[P_TBL[i]];
        return v;
    endfunction

    logic [1:48] w_mix;

    assign w_mix = f_expand(i_r) ^ i_k;
    assign o_f   = f_perm(f_sbox(w_mix));

endmodule
`default_nettype wire

// File: rtl/des_iter_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : des_iter_ctrl
// Brief    : Iterative DES engine, one Feistel round per clock, 16-cycle latency.
//            Define DES_PARITY_CHECK_EN to reject keys failing odd byte parity.
// Revision : 1.0
// ============================================================================
module des_iter_ctrl
    import des_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    des_iter_ctrl_if.slave   bus
);

    state_t      r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [1:64] r_ct;
    logic [4:0]  r_round;
    logic [1:32] r_l;
    logic [1:32] r_r;
    logic [1:28] r_c;
    logic [1:28] r_d;
    logic        r_decrypt;

    logic [1:0]  w_shl;
    logic [1:0]  w_shr;
    logic [1:28] w_c_rotl;
    logic [1:28] w_d_rotl;
    logic [1:28] w_c_rotr;
    logic [1:28] w_d_rotr;
    logic [1:48] w_k;
    logic [1:32] w_f;
    logic [1:32] w_r_next;
    logic [1:64] w_ip;
    logic [1:56] w_pc1;

    assign w_ip  = f_ip(bus.plaintext);
    assign w_pc1 = f_pc1(bus.key);

    // Encryption rotates before deriving Kr; decryption derives Kr first,
    // then un-rotates so the schedule walks K16..K1.
    assign w_shl    = f_shift(r_round);
    assign w_shr    = f_shift(5'd17 - r_round);
    assign w_c_rotl = f_rotl28(r_c, w_shl);
    assign w_d_rotl = f_rotl28(r_d, w_shl);
    assign w_c_rotr = f_rotr28(r_c, w_shr);
    assign w_d_rotr = f_rotr28(r_d, w_shr);
    assign w_k      = r_decrypt ? f_pc2({r_c, r_d}) : f_pc2({w_c_rotl, w_d_rotl});

    des_f u_des_f (
        .i_r (r_r),
        .i_k (w_k),
        .o_f (w_f)
    );

    assign w_r_next = r_l ^ w_f;

`ifdef DES_PARITY_CHECK_EN
    logic r_inv_key;
    logic w_key_bad;
    assign w_key_bad   = f_parity_bad(bus.key);
    assign bus.inv_key = r_inv_key;
`else
    assign bus.inv_key = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_ct        <= '0;
            r_round     <= '0;
            r_l         <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_decrypt   <= 1'b0;
`ifdef DES_PARITY_CHECK_EN
            r_inv_key   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_l        <= w_ip[1:32];
                        r_r        <= w_ip[33:64];
                        r_c        <= w_pc1[1:28];
                        r_d        <= w_pc1[29:56];
                        r_decrypt  <= bus.encry_decry;
                        r_round    <= 5'd1;
                        r_in_ready <= 1'b0;
`ifdef DES_PARITY_CHECK_EN
                        r_inv_key  <= w_key_bad;
                        if (w_key_bad) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_ct        <= '0;
                        end else begin
                            r_state     <= ROUND;
                        end
`else
                        r_state    <= ROUND;
`endif
                    end
                end
                ROUND: begin
                    r_l <= r_r;
                    r_r <= w_r_next;
                    if (r_decrypt) begin
                        r_c <= w_c_rotr;
                        r_d <= w_d_rotr;
                    end else begin
                        r_c <= w_c_rotl;
                        r_d <= w_d_rotl;
                    end
                    if (r_round == ROUNDS) begin
                        // Final swap is folded in: output block is {R16, L16}.
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_ct        <= f_fp({w_r_next, r_r});
                    end else begin
                        r_round     <= r_round + 5'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.ciphertext = r_ct;

endmodule
`default_nettype wire
